// File: rtl/rp2a03_alu_ctrl_pkg.sv
// rtl/rp2a03_alu_ctrl_pkg.sv - shared op codes, states, flag indices and decimal constants
package rp2a03_pkg;

  typedef enum logic [3:0] {
    OP_ADC = 4'h0,
    OP_SBC = 4'h1,
    OP_CMP = 4'h2,
    OP_AND = 4'h3,
    OP_EOR = 4'h4,
    OP_ORA = 4'h5,
    OP_ASL = 4'h6,
    OP_LSR = 4'h7,
    OP_ROL = 4'h8,
    OP_ROR = 4'h9,
    OP_INC = 4'hA,
    OP_DEC = 4'hB,
    OP_BIT = 4'hC
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EXEC = 3'd2,
    S_ADJ  = 3'd3,
    S_DONE = 3'd4
  } ctrl_state_e;

  // Bit positions inside the {N,Z,C,V} write mask
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // One-hot ALU enables {SRS,ORS,EORS,ANDS,SUMS}
  localparam logic [4:0] EN_SUMS = 5'b00001;
  localparam logic [4:0] EN_ANDS = 5'b00010;
  localparam logic [4:0] EN_EORS = 5'b00100;
  localparam logic [4:0] EN_ORS  = 5'b01000;
  localparam logic [4:0] EN_SRS  = 5'b10000;

  localparam logic [7:0] DEC_ADC_LO   = 8'h06;
  localparam logic [7:0] DEC_ADC_HI   = 8'h60;
  localparam logic [7:0] DEC_ADC_BOTH = 8'h66;
  localparam logic [7:0] DEC_SBC_LO   = 8'hFA;
  localparam logic [7:0] DEC_SBC_HI   = 8'hA0;
  localparam logic [7:0] DEC_SBC_BOTH = 8'h9A;

  function automatic logic [3:0] op_flag_we(input logic [3:0] op);
    logic [3:0] m;
    m = 4'b0000;
    case (op)
      OP_ADC, OP_SBC:                         m = 4'b1111;
      OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR: m = 4'b1110;
      OP_AND, OP_EOR, OP_ORA, OP_INC, OP_DEC: m = 4'b1100;
      OP_BIT:                                 m = 4'b1101;
      default:                                m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic op_result_we(input logic [3:0] op);
    return (op <= OP_BIT) && (op != OP_CMP) && (op != OP_BIT);
  endfunction

endpackage

// File: rtl/rp2a03_alu_ctrl_if.sv
// rtl/rp2a03_alu_ctrl_if.sv - request/result bus between decoder and ALU sequencer
interface rp2a03_alu_ctrl_if #(
  parameter int OP_W = 4
);
  logic            start;
  logic [OP_W-1:0] op;
  logic [7:0]      a_in;
  logic [7:0]      operand;
  logic            c_in;
  logic            d_in;
  logic            busy;
  logic            done;
  logic [7:0]      result;
  logic            result_we;
  logic            n_out;
  logic            z_out;
  logic            c_out;
  logic            v_out;
  logic [3:0]      flag_we;

  modport master (
    output start, op, a_in, operand, c_in, d_in,
    input  busy, done, result, result_we, n_out, z_out, c_out, v_out, flag_we
  );

  modport slave (
    input  start, op, a_in, operand, c_in, d_in,
    output busy, done, result, result_we, n_out, z_out, c_out, v_out, flag_we
  );
endinterface

// File: rtl/rp2a03_alu_ctrl_alu.sv
// rtl/rp2a03_alu_ctrl_alu.sv - combinational RP2A03 ALU: SUMS/ANDS/EORS/ORS/SRS
module RP2A03_ALU (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  input  logic       i_sums,
  input  logic       i_ands,
  input  logic       i_eors,
  input  logic       i_ors,
  input  logic       i_srs,
  output logic [7:0] o_out,
  output logic       o_carry,
  output logic       o_overflow,
  output logic       o_half_carry
);
  logic [8:0] w_sum;
  logic [4:0] w_lo;

  assign w_sum        = {1'b0, i_a} + {1'b0, i_b} + {8'h00, i_cin};
  assign w_lo         = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'h0, i_cin};
  assign o_half_carry = w_lo[4];

  always_comb begin
    o_out      = 8'h00;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    if (i_sums) begin
      o_out      = w_sum[7:0];
      o_carry    = w_sum[8];
      o_overflow = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
    end else if (i_ands) begin
      o_out = i_a & i_b;
    end else if (i_eors) begin
      o_out = i_a ^ i_b;
    end else if (i_ors) begin
      o_out = i_a | i_b;
    end else if (i_srs) begin
      o_out   = {1'b0, i_a[7:1]};
      o_carry = i_a[0];
    end
  end
endmodule

// File: rtl/rp2a03_alu_ctrl.sv
// rtl/rp2a03_alu_ctrl.sv - ALU sequencer: LOAD/EXEC(/ADJ)/DONE around RP2A03_ALU
// Optional decimal mode: RP2A03_ALU_CTRL_DECIMAL_EN
module rp2a03_alu_ctrl #(
  parameter int OP_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  rp2a03_alu_ctrl_if.slave bus
);
  import rp2a03_pkg::*;

  ctrl_state_e r_state;
  ctrl_state_e w_state_nxt;

  logic [OP_W-1:0] w_op_raw;
  logic [3:0]      r_op;
  logic [7:0]      r_a;
  logic [7:0]      r_operand;
  logic            r_cin;

  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic       r_alu_cin;
  logic [4:0] r_alu_en;

  logic [7:0] w_ld_a;
  logic [7:0] w_ld_b;
  logic       w_ld_cin;
  logic [4:0] w_ld_en;

  logic [7:0] w_alu_out;
  logic       w_alu_carry;
  logic       w_alu_ovf;
  logic       w_alu_hc;

  logic [7:0] r_result;
  logic       r_n, r_z, r_c, r_v;
  logic       r_done;
  logic       r_result_we;
  logic [3:0] r_flag_we;

  logic [7:0] w_fin_res;
  logic       w_fin_n, w_fin_z, w_fin_c, w_fin_v;
  logic       w_fin_we;
  logic [3:0] w_fin_fwe;

  logic w_accept;
  logic w_finish;
  logic w_dec;

  assign w_op_raw = bus.op;
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_finish = ((r_state == S_EXEC) || (r_state == S_ADJ)) && (w_state_nxt == S_DONE);

`ifdef RP2A03_ALU_CTRL_DECIMAL_EN
  logic       r_din;
  logic       r_dec_c;
  logic       r_dec_v;
  logic       w_adj_lo;
  logic       w_adj_hi;
  logic [7:0] w_corr;
  logic       w_corr_c;

  assign w_dec = r_din && ((r_op == OP_ADC) || (r_op == OP_SBC));

  // Correction from the binary EXEC pass: nibble carries for ADC, nibble borrows for SBC
  always_comb begin
    w_adj_lo = 1'b0;
    w_adj_hi = 1'b0;
    w_corr   = 8'h00;
    w_corr_c = w_alu_carry;
    if (r_op == OP_ADC) begin
      w_adj_lo = w_alu_hc || (w_alu_out[3:0] > 4'h9);
      w_adj_hi = w_alu_carry || (w_alu_out > 8'h99);
      w_corr   = (w_adj_lo && w_adj_hi) ? DEC_ADC_BOTH :
                 w_adj_hi ? DEC_ADC_HI : (w_adj_lo ? DEC_ADC_LO : 8'h00);
      w_corr_c = w_adj_hi;
    end else begin
      w_adj_lo = !w_alu_hc;
      w_adj_hi = !w_alu_carry;
      w_corr   = (w_adj_lo && w_adj_hi) ? DEC_SBC_BOTH :
                 w_adj_hi ? DEC_SBC_HI : (w_adj_lo ? DEC_SBC_LO : 8'h00);
      w_corr_c = w_alu_carry;
    end
  end
`else
  logic w_unused_hc;
  assign w_dec       = 1'b0;
  assign w_unused_hc = w_alu_hc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_EXEC;
      S_EXEC: w_state_nxt = w_dec ? S_ADJ : S_DONE;
`ifdef RP2A03_ALU_CTRL_DECIMAL_EN
      S_ADJ:  w_state_nxt = S_DONE;
`endif
      S_DONE: w_state_nxt = bus.start ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Illegal ops pass a_in through ORS with B=0 so one enable is always active
  always_comb begin
    w_ld_a   = r_a;
    w_ld_b   = r_operand;
    w_ld_cin = 1'b0;
    w_ld_en  = EN_SUMS;
    case (r_op)
      OP_ADC: w_ld_cin = r_cin;
      OP_SBC: begin w_ld_b = ~r_operand; w_ld_cin = r_cin; end
      OP_CMP: begin w_ld_b = ~r_operand; w_ld_cin = 1'b1; end
      OP_AND: w_ld_en = EN_ANDS;
      OP_EOR: w_ld_en = EN_EORS;
      OP_ORA: w_ld_en = EN_ORS;
      OP_ASL: w_ld_a = r_operand;
      OP_ROL: begin w_ld_a = r_operand; w_ld_cin = r_cin; end
      OP_LSR, OP_ROR: begin w_ld_a = r_operand; w_ld_en = EN_SRS; end
      OP_INC: begin w_ld_a = r_operand; w_ld_b = 8'h01; end
      OP_DEC: begin w_ld_a = r_operand; w_ld_b = 8'hFF; end
      OP_BIT: w_ld_en = EN_ANDS;
      default: begin w_ld_b = 8'h00; w_ld_en = EN_ORS; end
    endcase
  end

  RP2A03_ALU u_alu (
    .i_a          (r_alu_a),
    .i_b          (r_alu_b),
    .i_cin        (r_alu_cin),
    .i_sums       (r_alu_en[0]),
    .i_ands       (r_alu_en[1]),
    .i_eors       (r_alu_en[2]),
    .i_ors        (r_alu_en[3]),
    .i_srs        (r_alu_en[4]),
    .o_out        (w_alu_out),
    .o_carry      (w_alu_carry),
    .o_overflow   (w_alu_ovf),
    .o_half_carry (w_alu_hc)
  );

  always_comb begin
    w_fin_res = w_alu_out;
    if (r_op == OP_ROR) w_fin_res[7] = r_cin;
    w_fin_n   = w_fin_res[7];
    w_fin_z   = (w_fin_res == 8'h00);
    w_fin_c   = w_alu_carry;
    w_fin_v   = w_alu_ovf;
    w_fin_we  = op_result_we(r_op);
    w_fin_fwe = op_flag_we(r_op);
    if (r_op == OP_BIT) begin
      w_fin_n = r_operand[7];
      w_fin_v = r_operand[6];
      w_fin_z = (w_alu_out == 8'h00);
    end
`ifdef RP2A03_ALU_CTRL_DECIMAL_EN
    if (r_state == S_ADJ) begin
      w_fin_c   = r_dec_c;
      w_fin_v   = r_dec_v;
      w_fin_we  = 1'b1;
      w_fin_fwe = 4'b1111;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= 4'h0;
      r_a         <= 8'h00;
      r_operand   <= 8'h00;
      r_cin       <= 1'b0;
      r_alu_a     <= 8'h00;
      r_alu_b     <= 8'h00;
      r_alu_cin   <= 1'b0;
      r_alu_en    <= 5'b00000;
      r_result    <= 8'h00;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_done      <= 1'b0;
      r_result_we <= 1'b0;
      r_flag_we   <= 4'b0000;
`ifdef RP2A03_ALU_CTRL_DECIMAL_EN
      r_din       <= 1'b0;
      r_dec_c     <= 1'b0;
      r_dec_v     <= 1'b0;
`endif
    end else begin
      r_done      <= 1'b0;
      r_result_we <= 1'b0;
      r_flag_we   <= 4'b0000;
      if (w_accept) begin
        r_op      <= w_op_raw[3:0];
        r_a       <= bus.a_in;
        r_operand <= bus.operand;
        r_cin     <= bus.c_in;
`ifdef RP2A03_ALU_CTRL_DECIMAL_EN
        r_din     <= bus.d_in;
`endif
      end
      if (r_state == S_LOAD) begin
        r_alu_a   <= w_ld_a;
        r_alu_b   <= w_ld_b;
        r_alu_cin <= w_ld_cin;
        r_alu_en  <= w_ld_en;
      end
`ifdef RP2A03_ALU_CTRL_DECIMAL_EN
      // Second SUMS pass adds the correction to the binary result
      if ((r_state == S_EXEC) && w_dec) begin
        r_alu_a   <= w_alu_out;
        r_alu_b   <= w_corr;
        r_alu_cin <= 1'b0;
        r_alu_en  <= EN_SUMS;
        r_dec_c   <= w_corr_c;
        r_dec_v   <= w_alu_ovf;
      end
`endif
      if (w_finish) begin
        r_result    <= w_fin_res;
        r_n         <= w_fin_n;
        r_z         <= w_fin_z;
        r_c         <= w_fin_c;
        r_v         <= w_fin_v;
        r_done      <= 1'b1;
        r_result_we <= w_fin_we;
        r_flag_we   <= w_fin_fwe;
      end
    end
  end

  assign bus.busy      = (r_state == S_LOAD) || (r_state == S_EXEC) || (r_state == S_ADJ);
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.result_we = r_result_we;
  assign bus.n_out     = r_n;
  assign bus.z_out     = r_z;
  assign bus.c_out     = r_c;
  assign bus.v_out     = r_v;
  assign bus.flag_we   = r_flag_we;
endmodule

// File: doc/rp2a03_alu_ctrl.md
# rp2a03_alu_ctrl

- Sequencing front end for the RP2A03 ALU.
- Accepts one ALU micro-operation per request from the CPU control unit: ADC, SBC, CMP, logic, shifts, INC/DEC, BIT.
- Loads the ALU A/B input registers, drives exactly one ALU enable, captures OUT/CARRY/OVERFLOW, then returns a result with per-flag write enables to the datapath.
- Sits between the instruction decoder and the accumulator/status register; it instantiates the ALU internally.

## Interface
Parameters:
- OP_W, 4, width of the op code.

Ports:
- clk  input  1  system clock; one clock domain; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE or DONE.
- op  input  OP_W  operation: 0 ADC, 1 SBC, 2 CMP, 3 AND, 4 EOR, 5 ORA, 6 ASL, 7 LSR, 8 ROL, 9 ROR, A INC, B DEC, C BIT; D–F illegal.
- a_in  input  8  accumulator/register operand.
- operand  input  8  memory or immediate operand; shifts and INC/DEC act on this operand.
- c_in, d_in  input  1 each  current C and D flags.
- busy  output  1  high in LOAD, EXEC and ADJ.
- done  output  1  one-cycle pulse; result and flags are valid in that cycle.
- result  output  8  result value.
- result_we  output  1  result must be written back.
- n_out, z_out, c_out, v_out  output  1 each  new flag values.
- flag_we  output  4  write mask {N,Z,C,V}.

## Operation
States and transitions:
- IDLE → LOAD on start.
- LOAD → EXEC.
- EXEC → DONE, or EXEC → ADJ when a decimal adjust applies.
- ADJ → DONE.
- DONE → LOAD if start is high, else DONE → IDLE.

LOAD latches the ALU inputs, the op and c_in:
- ADC: A=a_in, B=operand, cin=c_in.
- SBC: A=a_in, B=~operand, cin=c_in.
- CMP: A=a_in, B=~operand, cin=1.
- AND/EOR/ORA: A=a_in, B=operand.
- ASL: A=B=operand, cin=0.
- ROL: A=B=operand, cin=c_in.
- LSR/ROR: A=operand; SRS selected.
- INC: A=operand, B=01, cin=0.
- DEC: A=operand, B=FF, cin=0.
- BIT: A=a_in, B=operand; ANDS selected.

EXEC:
- Exactly one ALU enable is high.
- OUT, CARRY and OVERFLOW are registered.
- For ROR, result[7] is replaced by the latched c_in.

Result and flag rules:
- N=result[7] and Z=(result==0) for every legal op except BIT.
- C is taken from the ALU CARRY for ADC/SBC/CMP/ASL/ROL/LSR/ROR.
- V is taken from the ALU OVERFLOW for ADC/SBC only.
- BIT: N=operand[7], V=operand[6], Z=((a_in&operand)==0); C is not written.
- result_we=1 for every legal op except CMP and BIT.

flag_we by op:
- ADC/SBC: 1111.
- CMP/ASL/LSR/ROL/ROR: 1110.
- AND/EOR/ORA/INC/DEC: 1100.
- BIT: 1101.
- Illegal op: result=a_in, result_we=0, flag_we=0000; done still pulses.

Boundary rules:
- start while busy is ignored; no queueing.
- The latched op and operands stay stable through completion even if the inputs change.
- Reset mid-operation aborts to IDLE; no done pulse follows.
- All arithmetic is mod 256; the carry is the 9th bit.

## Timing
- Reset values: every output 0; internal registers 0; state IDLE.
- start high at rising edge k:
  - busy is high in cycles k+1 and k+2.
  - done is high in cycle k+3.
- The decimal path adds one cycle, so done is high in cycle k+4.
- Outputs are registered; result and the flag outputs hold until the next done.
- done, result_we and flag_we are high only during the done cycle.
- Back-to-back throughput: start held high in the DONE cycle yields one result every 3 cycles.

## Configuration
- Macro: RP2A03_ALU_CTRL_DECIMAL_EN.
- Defined (MOS 6502 compatibility):
  - ADC/SBC with d_in=1 enter ADJ.
  - ADJ makes a second SUMS pass adding the correction: +06 or +66/+60 for ADC, FA/9A/A0 for SBC.
  - Correction is chosen from the nibble carry/borrow of the EXEC pass.
  - C comes from the decimal rule; V comes from the EXEC pass; N and Z come from the adjusted result.
- Undefined (RP2A03 behaviour): d_in is ignored, the ADJ state is not compiled, and latency is always 3.

## Structure
- Shared package rp2a03_pkg holds:
  - the alu_op_e enum (the op codes above);
  - the ctrl_state_e enum;
  - the flag index constants FLAG_N/Z/C/V;
  - the decimal correction constants.
- One sub-module: RP2A03_ALU, instantiated unchanged with its inputs driven from the LOAD registers.

## Test plan
- Reset mid-op: assert rst_n=0 in EXEC → all outputs 0, no done, state IDLE; the next start completes normally.
- ADC overflow: a_in=50, operand=50, c_in=0 → result A0, N=1 Z=0 C=0 V=1, flag_we 1111, done exactly at k+3.
- CMP equal: a_in=operand=3C → C=1, Z=1, N=0, result_we=0, flag_we 1110.
- ROR with carry in: operand=01, c_in=1 → result 80, C=1, N=1.
- BIT: a_in=0F, operand=C0 → Z=1, N=1, V=1, flag_we 1101, result_we=0.
- Back-to-back: INC FF then DEC 00 with start held high → results 00 (Z=1) then FF (N=1), done pulses 3 cycles apart; start during busy is ignored.
- Decimal (RP2A03_ALU_CTRL_DECIMAL_EN defined): ADC with d_in=1, a_in=15, operand=27 → result 42, done at k+4.
